// File: rtl/hexa7seg_mensagem.sv
`default_nettype none
// ============================================================================
//  Module      : hexa7seg_mensagem
//  Description : Drives N_DISPLAYS active-low 7-segment displays from a
//                message of MSG_LEN 5-bit character codes. Supports static,
//                blink and scroll modes. Outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module hexa7seg_mensagem #(
    parameter int N_DISPLAYS   = 6,
    parameter int MSG_LEN      = 8,
    parameter int BLINK_TICKS  = 25000000,
    parameter int SCROLL_TICKS = 25000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      habilita,
    input  logic [1:0]                modo,
    input  logic [5*MSG_LEN-1:0]      mensagem,
    output logic [7*N_DISPLAYS-1:0]   segs,
    output logic                      fim_ciclo
);

    // Shared divider must cover the longer of the two periods
    localparam int c_DIV_MAX = (BLINK_TICKS > SCROLL_TICKS) ? BLINK_TICKS : SCROLL_TICKS;
    localparam int c_CNT_W   = (c_DIV_MAX > 1) ? $clog2(c_DIV_MAX) : 1;
    localparam int c_OFF_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [c_CNT_W-1:0] c_BLINK_LAST  = c_CNT_W'(BLINK_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_SCROLL_LAST = c_CNT_W'(SCROLL_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_OFF_W-1:0] c_OFF_LAST    = c_OFF_W'(MSG_LEN - 1);
    localparam logic [c_OFF_W-1:0] c_OFF_ONE     = c_OFF_W'(1);

    // Display modes; 2'b11 falls through to the static behaviour
    localparam logic [1:0] c_MODO_STATIC = 2'b00;
    localparam logic [1:0] c_MODO_BLINK  = 2'b01;
    localparam logic [1:0] c_MODO_SCROLL = 2'b10;

    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    logic [c_CNT_W-1:0]        r_div_cnt;
    logic                      r_fase;
    logic [c_OFF_W-1:0]        r_offset;
    logic [1:0]                r_modo_ant;
    logic [7*N_DISPLAYS-1:0]   r_segs;
    logic                      r_fim_ciclo;

    logic [c_CNT_W-1:0]        w_div_nxt;
    logic                      w_fase_nxt;
    logic [c_OFF_W-1:0]        w_off_nxt;
    logic                      w_fim_nxt;
    logic [7*N_DISPLAYS-1:0]   w_segs_nxt;
    int                        w_idx;

    // Character code to active-low segment pattern (bit i = segment i)
    function automatic logic [6:0] f_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000; // A
            5'd11:   seg = 7'b0000011; // b
            5'd12:   seg = 7'b1000110; // C
            5'd13:   seg = 7'b0100001; // d
            5'd14:   seg = 7'b0000110; // E
            5'd15:   seg = 7'b0001110; // F
            5'd16:   seg = 7'b1000010; // G
            5'd17:   seg = 7'b0001001; // H
            5'd18:   seg = 7'b1100001; // J
            5'd19:   seg = 7'b1000111; // L
            5'd20:   seg = 7'b0101011; // n
            5'd21:   seg = 7'b0100011; // o
            5'd22:   seg = 7'b0001100; // P
            5'd23:   seg = 7'b0101111; // r
            5'd24:   seg = 7'b0000111; // t
            5'd25:   seg = 7'b1000001; // U
            5'd26:   seg = 7'b0010001; // y
            5'd27:   seg = c_SEG_DASH;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One-hot mux that picks character idx out of the packed message
    function automatic logic [4:0] f_pick(input logic [5*MSG_LEN-1:0] msg, input int idx);
        logic [4:0] code;
        code = 5'd31;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (idx == k) begin
                code = msg[5*k +: 5];
            end
        end
        return code;
    endfunction

    // Next state of divider, blink phase and scroll offset
    always_comb begin
        w_div_nxt  = r_div_cnt;
        w_fase_nxt = r_fase;
        w_off_nxt  = r_offset;
        w_fim_nxt  = 1'b0;
        if (!habilita || (modo != r_modo_ant)) begin
            // Disabled or freshly switched: restart from offset 0, visible
            w_div_nxt  = '0;
            w_fase_nxt = 1'b1;
            w_off_nxt  = '0;
        end else if (modo == c_MODO_BLINK) begin
            if (r_div_cnt == c_BLINK_LAST) begin
                w_div_nxt  = '0;
                w_fase_nxt = ~r_fase;
            end else begin
                w_div_nxt  = r_div_cnt + c_CNT_ONE;
            end
        end else if (modo == c_MODO_SCROLL) begin
            if (r_div_cnt == c_SCROLL_LAST) begin
                w_div_nxt = '0;
                if (r_offset == c_OFF_LAST) begin
                    w_off_nxt = '0;
                    w_fim_nxt = 1'b1;
                end else begin
                    w_off_nxt = r_offset + c_OFF_ONE;
                end
            end else begin
                w_div_nxt = r_div_cnt + c_CNT_ONE;
            end
        end else begin
            // c_MODO_STATIC and the reserved code: counters parked
            w_div_nxt  = '0;
            w_fase_nxt = 1'b1;
            w_off_nxt  = '0;
        end
    end

    // Build the whole display image from the next-state view so every digit updates together
    always_comb begin
        w_segs_nxt = '1;
        w_idx      = 0;
        for (int d = 0; d < N_DISPLAYS; d++) begin
            // offset < MSG_LEN and d < N_DISPLAYS <= MSG_LEN, so one subtraction suffices
            w_idx = int'(w_off_nxt) + d;
            if (w_idx >= MSG_LEN) begin
                w_idx = w_idx - MSG_LEN;
            end
            if (!habilita) begin
                w_segs_nxt[7*d +: 7] = c_SEG_DASH;
            end else if (!w_fase_nxt) begin
                w_segs_nxt[7*d +: 7] = c_SEG_BLANK;
            end else begin
                w_segs_nxt[7*d +: 7] = f_decode(f_pick(mensagem, w_idx));
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div_cnt   <= '0;
            r_fase      <= 1'b1;
            r_offset    <= '0;
            r_modo_ant  <= c_MODO_STATIC;
            r_segs      <= '1;
            r_fim_ciclo <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_nxt;
            r_fase      <= w_fase_nxt;
            r_offset    <= w_off_nxt;
            r_modo_ant  <= modo;
            r_segs      <= w_segs_nxt;
            r_fim_ciclo <= w_fim_nxt;
        end
    end

    assign segs      = r_segs;
    assign fim_ciclo = r_fim_ciclo;

endmodule
`default_nettype wire
